// File: rtl/dut_test_pkg.sv
// Shared types and defaults for the loopback test pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dut_test_pkg;

  // Per-beat lane operation; travels alongside its beat.
  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_INV   = 2'd1,
    MODE_INCR  = 2'd2,
    MODE_ACCUM = 2'd3
  } mode_e;

  localparam int DEF_SIG_WIDTH = 256;
  localparam int DEF_LANES     = 8;
  localparam int DEF_LATENCY   = 2;
  localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/dut_test_lane.sv
// One lane: selectable op (pass/invert/increment/accumulate) with registered result.
// Latency: 1 cycle from vld to r; r holds its value when vld is low.
// Backpressure: none; every vld beat is accepted.
module dut_test_lane
  import dut_test_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANE_W-1:0] x,
  input  logic              vld,
  input  mode_e             mode,
  input  logic              acc_clr,
  output logic [LANE_W-1:0] r
);

  logic [LANE_W-1:0] acc;
  logic [LANE_W-1:0] acc_base;
  logic [LANE_W-1:0] sum;
  logic [LANE_W-1:0] r_nxt;

  // Op mux; a clear in the same cycle as an accumulate means clear-then-add.
  always_comb begin
    acc_base = acc_clr ? '0 : acc;
    sum      = acc_base + x;
    r_nxt    = x;
    case (mode)
      MODE_PASS:  r_nxt = x;
      MODE_INV:   r_nxt = ~x;
      MODE_INCR:  r_nxt = x + LANE_W'(1);
      MODE_ACCUM: r_nxt = sum;
      default:    r_nxt = x;
    endcase
  end

  // Accumulator moves only on an accumulate beat or a clear; result register only on a beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      r   <= '0;
    end else begin
      if (vld && mode == MODE_ACCUM) begin
        acc <= sum;
      end else if (acc_clr) begin
        acc <= '0;
      end
      if (vld) begin
        r <= r_nxt;
      end
    end
  end

endmodule

// File: rtl/dut_test_pipe.sv
// Lane-split transform DUT for loopback tests: per-lane op, then a valid-tagged delay line.
// Latency: exactly LATENCY cycles from in_valid to out_valid.
// Backpressure: none; out holds its last value on cycles without out_valid.
module dut_test_pipe
  import dut_test_pkg::*;
#(
  parameter int SIG_WIDTH = DEF_SIG_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SIG_WIDTH-1:0] in,
  input  logic                 in_valid,
  input  mode_e                mode,
  input  logic                 acc_clr,
  output logic [SIG_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int LANE_W = SIG_WIDTH / LANES;

  if (SIG_WIDTH % LANES != 0) begin : g_bad_lanes
    $error("dut_test_pipe: SIG_WIDTH must be a multiple of LANES");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("dut_test_pipe: LATENCY must be at least 1");
  end

  logic [SIG_WIDTH-1:0] s0_dat;
  logic                 s0_vld;
  logic                 cnt_inc;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dut_test_lane #(
      .LANE_W (LANE_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .x       (in[k*LANE_W +: LANE_W]),
      .vld     (in_valid),
      .mode    (mode),
      .acc_clr (acc_clr),
      .r       (s0_dat[k*LANE_W +: LANE_W])
    );
  end

  // Stage-0 valid tag, aligned with the lane result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_vld <= 1'b0;
    end else begin
      s0_vld <= in_valid;
    end
  end

  if (LATENCY == 1) begin : g_lat1
    assign out       = s0_dat;
    assign out_valid = s0_vld;
    assign cnt_inc   = in_valid;
  end else begin : g_latn
    logic [SIG_WIDTH-1:0] dly_dat [LATENCY-1];
    logic [LATENCY-2:0]   dly_vld;
    logic [LATENCY-1:0]   vld_in;

    // Bit i is the valid entering delay stage i.
    assign vld_in = {dly_vld, s0_vld};

    // Delay stages; data only advances with a valid so out holds between beats.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY - 1; i++) begin
          dly_dat[i] <= '0;
        end
        dly_vld <= '0;
      end else begin
        dly_vld <= vld_in[LATENCY-2:0];
        if (s0_vld) begin
          dly_dat[0] <= s0_dat;
        end
        for (int i = 1; i < LATENCY - 1; i++) begin
          if (dly_vld[i-1]) begin
            dly_dat[i] <= dly_dat[i-1];
          end
        end
      end
    end

    assign out       = dly_dat[LATENCY-2];
    assign out_valid = dly_vld[LATENCY-2];
    assign cnt_inc   = vld_in[LATENCY-2];
  end

  // Counts emitted beats; steps on the same edge that raises out_valid, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (cnt_inc) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dut_test_pipe.sv
// Scoreboard bench: default 8x32 pipe (LATENCY=2) and a 1-lane LATENCY=1 build with a short counter.
// Latency: checked cycle-exactly via a due cycle stored with every expected beat.
// Backpressure: none in the DUT; stimulus is free-running.
module tb_dut_test_pipe;
  import dut_test_pkg::*;

  localparam int W    = 256;
  localparam int L    = 8;
  localparam int LW   = 32;
  localparam int LAT  = 2;
  localparam int W1   = 32;
  localparam int LAT1 = 1;
  localparam int CW1  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  d_in;
  logic          d_vld;
  mode_e         d_mode;
  logic          d_clr;
  logic [W-1:0]  d_out;
  logic          d_ovld;
  logic [31:0]   d_cnt;

  logic [W1-1:0]  e_in;
  logic           e_vld;
  mode_e          e_mode;
  logic           e_clr;
  logic [W1-1:0]  e_out;
  logic           e_ovld;
  logic [CW1-1:0] e_cnt;

  dut_test_pipe #(.SIG_WIDTH(W), .LANES(L), .LATENCY(LAT), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(d_in), .in_valid(d_vld), .mode(d_mode),
    .acc_clr(d_clr), .out(d_out), .out_valid(d_ovld), .beat_cnt(d_cnt)
  );

  dut_test_pipe #(.SIG_WIDTH(W1), .LANES(1), .LATENCY(LAT1), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in(e_in), .in_valid(e_vld), .mode(e_mode),
    .acc_clr(e_clr), .out(e_out), .out_valid(e_ovld), .beat_cnt(e_cnt)
  );

  typedef struct {
    logic [W-1:0] dat;
    int           due;
  } exp_t;

  exp_t           q0[$];
  exp_t           q1[$];
  int             cyc = 0;
  int             n_vec = 0;
  int             n_err = 0;
  logic [LW-1:0]  acc0 [L];
  logic [W1-1:0]  acc1;
  logic [31:0]    cnt0;
  logic [CW1-1:0] cnt1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] lane_op(input mode_e m, input logic [LW-1:0] x,
                                             input logic [LW-1:0] a);
    case (m)
      MODE_PASS:  return x;
      MODE_INV:   return ~x;
      MODE_INCR:  return x + 32'd1;
      default:    return a + x;
    endcase
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    cnt0 = '0;
    cnt1 = '0;
    acc1 = '0;
    for (int k = 0; k < L; k++) acc0[k] = '0;
  endtask

  // One cycle on the wide DUT: check what is due now, then drive the next beat.
  task automatic step0(input bit v, input mode_e m, input bit clr, input logic [W-1:0] d,
                       input bit rst);
    exp_t          e;
    logic [W-1:0]  r;
    logic [LW-1:0] a;
    logic [LW-1:0] x;
    @(negedge clk);
    if (q0.size() > 0 && q0[0].due == cyc) begin
      chk("d0_vld", W'(d_ovld), W'(1));
      e = q0.pop_front();
      chk("d0_out", d_out, e.dat);
      cnt0++;
    end else begin
      chk("d0_vld", W'(d_ovld), W'(0));
    end
    chk("d0_cnt", W'(d_cnt), W'(cnt0));
    rst_n  = !rst;
    d_vld  = v && !rst;
    d_mode = m;
    d_clr  = clr && !rst;
    d_in   = d;
    if (rst) begin
      model_reset();
    end else begin
      r = '0;
      for (int k = 0; k < L; k++) begin
        x = d[k*LW +: LW];
        a = clr ? '0 : acc0[k];
        r[k*LW +: LW] = lane_op(m, x, a);
        if (v && m == MODE_ACCUM) acc0[k] = a + x;
        else if (clr) acc0[k] = '0;
      end
      if (v) begin
        e.dat = r;
        e.due = cyc + LAT;
        q0.push_back(e);
      end
    end
  endtask

  // One cycle on the single-lane LATENCY=1 DUT.
  task automatic step1(input bit v, input mode_e m, input bit clr, input logic [W1-1:0] d);
    exp_t          e;
    logic [LW-1:0] a;
    @(negedge clk);
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("d1_vld", W'(e_ovld), W'(1));
      e = q1.pop_front();
      chk("d1_out", W'(e_out), e.dat);
      cnt1++;
    end else begin
      chk("d1_vld", W'(e_ovld), W'(0));
    end
    chk("d1_cnt", W'(e_cnt), W'(cnt1));
    e_vld  = v;
    e_mode = m;
    e_clr  = clr;
    e_in   = d;
    a = clr ? '0 : acc1;
    if (v && m == MODE_ACCUM) acc1 = a + d;
    else if (clr) acc1 = '0;
    if (v) begin
      e.dat = W'(lane_op(m, d, a));
      e.due = cyc + LAT1;
      q1.push_back(e);
    end
  endtask

  logic [W-1:0] rnd;

  initial begin
    rst_n  = 1'b0;
    d_in   = '0;
    d_vld  = 1'b0;
    d_mode = MODE_PASS;
    d_clr  = 1'b0;
    e_in   = '0;
    e_vld  = 1'b0;
    e_mode = MODE_PASS;
    e_clr  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);

    // Reset state
    step0(0, MODE_PASS, 0, '0, 1);
    step0(0, MODE_PASS, 0, '0, 0);
    chk("rst_out", d_out, '0);
    chk("rst_out1", W'(e_out), '0);

    // Pass-through with cycle-exact latency
    step0(1, MODE_PASS, 0, 256'h1c1d1e1f_18191a1b_14151617_10111213_0c0d0e0f_08090a0b_04050607_01020304, 0);
    repeat (3) step0(0, MODE_PASS, 0, '0, 0);

    // Invert and per-lane increment, no carry across lanes
    step0(1, MODE_INV, 0, '0, 0);
    step0(1, MODE_INCR, 0, {160'h0, 32'h7fff_ffff, 32'h0000_0005, 32'hffff_ffff}, 0);
    step0(0, MODE_PASS, 0, '0, 0);

    // Accumulate on lane 3 back to back: 10, 30, 60
    step0(1, MODE_ACCUM, 0, {128'h0, 32'd10, 96'h0}, 0);
    step0(1, MODE_ACCUM, 0, {128'h0, 32'd20, 96'h0}, 0);
    step0(1, MODE_ACCUM, 0, {128'h0, 32'd30, 96'h0}, 0);

    // Clear-then-add, then continue, then clear alone
    step0(1, MODE_ACCUM, 1, {128'h0, 32'd7, 96'h0}, 0);
    step0(1, MODE_ACCUM, 0, {128'h0, 32'd1, 96'h0}, 0);
    step0(0, MODE_PASS, 1, '0, 0);
    step0(1, MODE_ACCUM, 0, {128'h0, 32'd4, 96'h0}, 0);
    // Clear alongside a non-accumulate beat
    step0(1, MODE_INCR, 1, {8{32'h0000_0009}}, 0);
    step0(1, MODE_ACCUM, 0, {8{32'h0000_0002}}, 0);
    repeat (3) step0(0, MODE_PASS, 0, '0, 0);

    // Randomised traffic with gaps, then reset with beats in flight
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < L; k++) rnd[k*LW +: LW] = $urandom();
      step0((i % 3) != 1, mode_e'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, rnd, 0);
    end
    step0(0, MODE_PASS, 0, '0, 1);
    step0(1, MODE_ACCUM, 0, {8{32'd5}}, 0);
    for (int i = 0; i < LAT + 3 && q0.size() > 0; i++) step0(0, MODE_PASS, 0, '0, 0);
    chk("d0_drain", W'(q0.size()), W'(0));

    // Latency-1 single lane: full-width increment wrap and short counter wrap
    step1(1, MODE_INCR, 0, 32'hffff_ffff);
    step1(1, MODE_PASS, 0, 32'h1234_5678);
    step1(0, MODE_PASS, 0, '0);
    step1(1, MODE_ACCUM, 0, 32'hffff_fffe);
    step1(1, MODE_ACCUM, 0, 32'd3);
    step1(1, MODE_ACCUM, 1, 32'd11);
    for (int i = 0; i < 30; i++) begin
      step1((i % 4) != 3, mode_e'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, $urandom());
    end
    for (int i = 0; i < LAT1 + 3 && q1.size() > 0; i++) step1(0, MODE_PASS, 0, '0);
    chk("d1_drain", W'(q1.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
